// File: rtl/dbus_uncached_buffer_pkg.sv
// rtl/dbus_uncached_buffer_pkg.sv - shared types and sizes for the uncached data-bus buffer
package dbus_uncached_buffer_pkg;

    localparam int UNCACHED_WBUF_DEPTH = 4;
    localparam int UNCACHED_ADDR_WIDTH = 32;
    localparam int UNCACHED_DATA_WIDTH = 32;
    localparam int UNCACHED_BE_WIDTH   = UNCACHED_DATA_WIDTH / 8;

    typedef struct packed {
        logic [UNCACHED_ADDR_WIDTH-1:0] addr;
        logic [UNCACHED_DATA_WIDTH-1:0] wrdata;
        logic [UNCACHED_BE_WIDTH-1:0]   be;
    } uncached_wreq_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_DONE = 2'd3
    } rd_state_e;

endpackage

// File: rtl/dbus_uncached_buffer_if.sv
// rtl/dbus_uncached_buffer_if.sv - MEM-stage request side and downstream bus side of the uncached port
interface dbus_uncached_buffer_if;
    import dbus_uncached_buffer_pkg::*;

    logic                           cpu_read;
    logic                           cpu_write;
    logic [UNCACHED_ADDR_WIDTH-1:0] cpu_addr;
    logic [UNCACHED_DATA_WIDTH-1:0] cpu_wrdata;
    logic [UNCACHED_BE_WIDTH-1:0]   cpu_be;
    logic [UNCACHED_DATA_WIDTH-1:0] cpu_rddata;
    logic                           cpu_stall;
    logic                           wb_empty;
    logic                           bus_req;
    logic                           bus_we;
    logic [UNCACHED_ADDR_WIDTH-1:0] bus_addr;
    logic [UNCACHED_DATA_WIDTH-1:0] bus_wdata;
    logic [UNCACHED_BE_WIDTH-1:0]   bus_be;
    logic                           bus_ack;
    logic [UNCACHED_DATA_WIDTH-1:0] bus_rdata;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wrdata, cpu_be, bus_ack, bus_rdata,
        input  cpu_rddata, cpu_stall, wb_empty, bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wrdata, cpu_be, bus_ack, bus_rdata,
        output cpu_rddata, cpu_stall, wb_empty, bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

endinterface

// File: rtl/dbus_uncached_buffer_wfifo.sv
// rtl/dbus_uncached_buffer_wfifo.sv - register FIFO of posted uncached stores
module dbus_uncached_buffer_wfifo
    import dbus_uncached_buffer_pkg::*;
#(
    parameter int DEPTH = UNCACHED_WBUF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  uncached_wreq_t push_data_i,
    input  logic           pop_i,
    output uncached_wreq_t head_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    uncached_wreq_t  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // One extra count bit keeps full and empty distinct while pointers wrap
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dbus_uncached_buffer.sv
// rtl/dbus_uncached_buffer.sv - posted-store buffer and blocking read path for uncached accesses
module dbus_uncached_buffer
    import dbus_uncached_buffer_pkg::*;
#(
    parameter int DEPTH = UNCACHED_WBUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    dbus_uncached_buffer_if.slave bus_if
);

    rd_state_e                      state_q, state_d;
    logic                           bus_req_q, bus_req_d;
    logic                           bus_we_q, bus_we_d;
    logic [UNCACHED_ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [UNCACHED_DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [UNCACHED_BE_WIDTH-1:0]   bus_be_q, bus_be_d;
    logic [UNCACHED_DATA_WIDTH-1:0] rddata_q, rddata_d;

    uncached_wreq_t cpu_req;
    uncached_wreq_t fifo_head;
    uncached_wreq_t wr_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           wb_empty;
    logic           rd_start;

    assign cpu_req  = {bus_if.cpu_addr, bus_if.cpu_wrdata, bus_if.cpu_be};
    assign push     = bus_if.cpu_write & (state_q == ST_IDLE) & ~fifo_full;
    assign wb_empty = fifo_empty & ~(bus_req_q & bus_we_q);
    // A store pushed into an empty FIFO is issued straight from the CPU fields
    assign wr_head  = fifo_empty ? cpu_req : fifo_head;
    assign rd_start = wb_empty & (((state_q == ST_IDLE) & bus_if.cpu_read & ~bus_if.cpu_write)
                                  | (state_q == ST_DRAIN));

    dbus_uncached_buffer_wfifo #(.DEPTH(DEPTH)) u_wfifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(cpu_req),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rddata_q    <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            rddata_q    <= rddata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        rddata_d    = rddata_q;
        pop         = 1'b0;

        if (bus_req_q && bus_if.bus_ack) begin
            bus_req_d = 1'b0;
            pop       = bus_we_q;
        end else if (!bus_req_q && (!fifo_empty || push)) begin
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b1;
            bus_addr_d  = wr_head.addr;
            bus_wdata_d = wr_head.wrdata;
            bus_be_d    = wr_head.be;
        end

        // Reads only start once nothing is queued or in flight, so they never race the write path
        if (rd_start) begin
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b0;
            bus_addr_d = bus_if.cpu_addr;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_start)                                 state_d = ST_RD_REQ;
                else if (bus_if.cpu_read && !bus_if.cpu_write) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (rd_start) state_d = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (bus_if.bus_ack) begin
                    state_d  = ST_RD_DONE;
                    rddata_d = bus_if.bus_rdata;
                end
            end
            ST_RD_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign bus_if.cpu_stall  = (bus_if.cpu_write & (fifo_full | (state_q != ST_IDLE)))
                             | (bus_if.cpu_read & (state_q != ST_RD_DONE));
    assign bus_if.wb_empty   = wb_empty;
    assign bus_if.cpu_rddata = rddata_q;
    assign bus_if.bus_req    = bus_req_q;
    assign bus_if.bus_we     = bus_we_q;
    assign bus_if.bus_addr   = bus_addr_q;
    assign bus_if.bus_wdata  = bus_wdata_q;
    assign bus_if.bus_be     = bus_be_q;

endmodule
